xgmii_frame_gen: RTL and testbench



---
 rtl/xgmii_pkg.sv | 37 +++
 rtl/xgmii_term_lane.sv | 33 +++
 rtl/xgmii_frame_gen.sv | 192 +++++++++++++++++++
 tb/tb_xgmii_frame_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// Shared definitions for the XGMII transmit frame generator.
//   - XGMII control characters and preamble/SFD bytes
//   - Pre-built idle and start words (64-bit, lane 0 = [7:0])
//   - Frame generator state encoding
//   - payload_word(): eight consecutive incrementing payload bytes
package xgmii_pkg;

   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERROR = 8'hFE;

   localparam logic [7:0] PREAMBLE = 8'h55;
   localparam logic [7:0] SFD      = 8'hD5;

   localparam logic [63:0] IDLE_WORD  = {8{XGMII_IDLE}};
   localparam logic [63:0] START_WORD = {SFD, {6{PREAMBLE}}, XGMII_START};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_TERM,
      ST_IFG
   } state_t;

   // Lane i carries (base + i) mod 256.
   function automatic logic [63:0] payload_word(input logic [7:0] base);
      logic [63:0] w;
      w = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         w[8*i +: 8] = base + 8'(i);
      end
      return w;
   endfunction

endpackage

// File: rtl/xgmii_term_lane.sv
// Combinational builder of the XGMII terminate word.
//   rem    : remaining payload bytes in this word (len mod 8)
//   seed   : first payload byte of the frame
//   offset : payload byte index of lane 0 (mod 256)
//   txd    : lanes 0..rem-1 payload, lane rem = TERM, rest IDLE
//   txc    : control bits rem..7 set
module xgmii_term_lane
   import xgmii_pkg::*;
(
   input  logic [2:0]  rem,
   input  logic [7:0]  seed,
   input  logic [7:0]  offset,
   output logic [63:0] txd,
   output logic [7:0]  txc
);

   always_comb begin
      txd = '0;
      txc = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (3'(i) < rem) begin
            txd[8*i +: 8] = seed + offset + 8'(i);
         end else if (3'(i) == rem) begin
            txd[8*i +: 8] = XGMII_TERM;
            txc[i]        = 1'b1;
         end else begin
            txd[8*i +: 8] = XGMII_IDLE;
            txc[i]        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xgmii_frame_gen.sv
// Transmit-side XGMII traffic source.
// Builds START/preamble/SFD, an incrementing-byte payload of cfg_len bytes
// starting at cfg_seed, a terminate word, then an idle gap of
// max(cfg_ifg, IFG_MIN) words. Single-shot, or continuous while
// cfg_continuous is high (seed increments per frame).
// Ports:
//   tx_clk, tx_rst (sync, active-low)
//   start, cfg_len, cfg_seed, cfg_ifg, cfg_continuous : request/config
//   xgmii_txd, xgmii_txc : XGMII TX bus (registered)
//   busy, done, len_err, frame_count : status (registered)
module xgmii_frame_gen
   import xgmii_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH  = 14,
   parameter int MAX_LEN    = 9600,
   parameter int IFG_MIN    = 2
)
(
   input  logic                  tx_clk,
   input  logic                  tx_rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   input  logic [7:0]            cfg_seed,
   input  logic [7:0]            cfg_ifg,
   input  logic                  cfg_continuous,
   output logic [DATA_WIDTH-1:0] xgmii_txd,
   output logic [CTRL_WIDTH-1:0] xgmii_txc,
   output logic                  busy,
   output logic                  done,
   output logic                  len_err,
   output logic [15:0]           frame_count
);

   // state_q names the word currently on the bus; the combinational block
   // computes the following word so every output comes straight from a flop.
   state_t                  state_q, state_n;
   logic [LEN_WIDTH-1:0]    len_q, len_n;
   logic [7:0]              seed_q, seed_n;
   logic [7:0]              ifg_q, ifg_n;
   logic [LEN_WIDTH-4:0]    words_q, words_n;   // full data words still to send
   logic [7:0]              off_q, off_n;       // payload byte index of next word
   logic [7:0]              gap_q, gap_n;       // idle words left after current
   logic [DATA_WIDTH-1:0]   txd_q, txd_n;
   logic [CTRL_WIDTH-1:0]   txc_q, txc_n;
   logic                    busy_q, busy_n;
   logic                    done_q, done_n;
   logic                    len_err_q, len_err_n;
   logic [15:0]             count_q, count_n;

   logic                    len_ok;
   logic [7:0]              ifg_clamped;
   logic [63:0]             term_txd;
   logic [7:0]              term_txc;

   assign len_ok      = (cfg_len != '0) && (cfg_len <= LEN_WIDTH'(MAX_LEN));
   assign ifg_clamped = (cfg_ifg < 8'(IFG_MIN)) ? 8'(IFG_MIN) : cfg_ifg;

   xgmii_term_lane u_term (
      .rem    (len_q[2:0]),
      .seed   (seed_q),
      .offset (off_q),
      .txd    (term_txd),
      .txc    (term_txc)
   );

   always_comb begin
      state_n   = state_q;
      len_n     = len_q;
      seed_n    = seed_q;
      ifg_n     = ifg_q;
      words_n   = words_q;
      off_n     = off_q;
      gap_n     = gap_q;
      txd_n     = IDLE_WORD;
      txc_n     = '1;
      busy_n    = busy_q;
      done_n    = 1'b0;
      len_err_n = 1'b0;
      count_n   = count_q;

      case (state_q)
         ST_IDLE: begin
            busy_n = 1'b0;
            if (start) begin
               if (len_ok) begin
                  state_n = ST_START;
                  len_n   = cfg_len;
                  seed_n  = cfg_seed;
                  ifg_n   = ifg_clamped;
                  words_n = cfg_len[LEN_WIDTH-1:3];
                  off_n   = '0;
                  txd_n   = START_WORD;
                  txc_n   = 8'h01;
                  busy_n  = 1'b1;
               end else begin
                  len_err_n = 1'b1;
               end
            end
         end

         ST_START, ST_DATA: begin
            if (words_q != '0) begin
               state_n = ST_DATA;
               words_n = words_q - 1'b1;
               off_n   = off_q + 8'd8;
               txd_n   = payload_word(seed_q + off_q);
               txc_n   = '0;
            end else begin
               state_n = ST_TERM;
               txd_n   = term_txd;
               txc_n   = term_txc;
            end
         end

         ST_TERM: begin
            state_n = ST_IFG;
            gap_n   = ifg_q - 8'd1;
            if (ifg_q == 8'd1) begin
               done_n  = 1'b1;
               count_n = count_q + 16'd1;
            end
         end

         ST_IFG: begin
            if (gap_q != '0) begin
               gap_n = gap_q - 8'd1;
               if (gap_q == 8'd1) begin
                  done_n  = 1'b1;
                  count_n = count_q + 16'd1;
               end
            end else if (cfg_continuous) begin
               state_n = ST_START;
               seed_n  = seed_q + 8'd1;
               words_n = len_q[LEN_WIDTH-1:3];
               off_n   = '0;
               txd_n   = START_WORD;
               txc_n   = 8'h01;
            end else begin
               state_n = ST_IDLE;
               busy_n  = 1'b0;
            end
         end

         default: begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge tx_clk) begin
      if (!tx_rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         seed_q    <= '0;
         ifg_q     <= '0;
         words_q   <= '0;
         off_q     <= '0;
         gap_q     <= '0;
         txd_q     <= IDLE_WORD;
         txc_q     <= '1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         len_err_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_n;
         len_q     <= len_n;
         seed_q    <= seed_n;
         ifg_q     <= ifg_n;
         words_q   <= words_n;
         off_q     <= off_n;
         gap_q     <= gap_n;
         txd_q     <= txd_n;
         txc_q     <= txc_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
         len_err_q <= len_err_n;
         count_q   <= count_n;
      end
   end

   assign xgmii_txd   = txd_q;
   assign xgmii_txc   = txc_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign len_err     = len_err_q;
   assign frame_count = count_q;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Self-checking bench for xgmii_frame_gen: table of terminate-word and
// length-error vectors, hand sequences for reset/abort/continuous mode,
// and randomized frames checked word-by-word against a character-stream
// reference model.
module tb_xgmii_frame_gen;

   localparam int LEN_WIDTH = 14;
   localparam int MAX_LEN   = 9600;
   localparam int IFG_MIN   = 2;
   localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
   localparam logic [63:0] START_W = 64'hD5555555555555FB;

   logic                 tx_clk = 1'b0;
   logic                 tx_rst = 1'b0;
   logic                 start = 1'b0;
   logic [LEN_WIDTH-1:0] cfg_len = '0;
   logic [7:0]           cfg_seed = '0;
   logic [7:0]           cfg_ifg = '0;
   logic                 cfg_continuous = 1'b0;
   logic [63:0]          xgmii_txd;
   logic [7:0]           xgmii_txc;
   logic                 busy, done, len_err;
   logic [15:0]          frame_count;

   always #5 tx_clk = ~tx_clk;

   xgmii_frame_gen #(
      .DATA_WIDTH (64),
      .CTRL_WIDTH (8),
      .LEN_WIDTH  (LEN_WIDTH),
      .MAX_LEN    (MAX_LEN),
      .IFG_MIN    (IFG_MIN)
   ) dut (
      .tx_clk         (tx_clk),
      .tx_rst         (tx_rst),
      .start          (start),
      .cfg_len        (cfg_len),
      .cfg_seed       (cfg_seed),
      .cfg_ifg        (cfg_ifg),
      .cfg_continuous (cfg_continuous),
      .xgmii_txd      (xgmii_txd),
      .xgmii_txc      (xgmii_txc),
      .busy           (busy),
      .done           (done),
      .len_err        (len_err),
      .frame_count    (frame_count)
   );

   int errors = 0;
   int checks = 0;
   int fc_exp = 0;

   logic [63:0] q_txd[$];
   logic [7:0]  q_txc[$];
   logic        q_done[$];

   typedef struct {
      int          len;
      logic [7:0]  seed;
      logic [63:0] term_txd;
      logic [7:0]  term_txc;
      bit          err;
   } vec_t;

   vec_t tbl[$];

   task automatic tick();
      @(posedge tx_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_txd"},  xgmii_txd, IDLE_W);
      chk({tag, "_txc"},  64'(xgmii_txc), 64'hFF);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_fc"},   64'(frame_count), 64'(16'(fc_exp)));
   endtask

   // Reference: the frame is a stream of (ctrl,byte) characters -- payload,
   // then TERM, padded with IDLE to a word boundary -- then the idle gap.
   task automatic model_frame(input int len, input logic [7:0] seed, input int ifg);
      logic [8:0]  chars[$];
      logic [63:0] d;
      logic [7:0]  c;
      int          n_ifg;
      q_txd.push_back(START_W);
      q_txc.push_back(8'h01);
      q_done.push_back(1'b0);
      for (int k = 0; k < len; k++) chars.push_back({1'b0, seed + 8'(k)});
      chars.push_back({1'b1, 8'hFD});
      while (chars.size() % 8 != 0) chars.push_back({1'b1, 8'h07});
      for (int w = 0; w < chars.size() / 8; w++) begin
         for (int l = 0; l < 8; l++) begin
            d[8*l +: 8] = chars[8*w + l][7:0];
            c[l]        = chars[8*w + l][8];
         end
         q_txd.push_back(d);
         q_txc.push_back(c);
         q_done.push_back(1'b0);
      end
      n_ifg = (ifg < IFG_MIN) ? IFG_MIN : ifg;
      for (int j = 0; j < n_ifg; j++) begin
         q_txd.push_back(IDLE_W);
         q_txc.push_back(8'hFF);
         q_done.push_back(j == n_ifg - 1);
      end
   endtask

   task automatic issue(input int len, input logic [7:0] seed, input int ifg);
      cfg_len  = LEN_WIDTH'(len);
      cfg_seed = seed;
      cfg_ifg  = 8'(ifg);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Compare the bus against the queued expectation, starting with the word
   // already on the bus. With perturb set, start/cfg toggle while busy.
   task automatic run_stream(input bit perturb);
      for (int i = 0; i < q_txd.size(); i++) begin
         if (i > 0) begin
            if (perturb) begin
               start    = ($urandom_range(0, 3) == 0);
               cfg_len  = LEN_WIDTH'($urandom_range(0, 200));
               cfg_seed = 8'($urandom);
               cfg_ifg  = 8'($urandom_range(0, 9));
            end
            tick();
         end
         if (q_done[i]) fc_exp++;
         chk("stream_txd",  xgmii_txd, q_txd[i]);
         chk("stream_txc",  64'(xgmii_txc), 64'(q_txc[i]));
         chk("stream_busy", 64'(busy), 64'd1);
         chk("stream_done", 64'(done), 64'(q_done[i]));
         chk("stream_lerr", 64'(len_err), 64'd0);
         chk("stream_fc",   64'(frame_count), 64'(16'(fc_exp)));
      end
      start          = 1'b0;
      cfg_continuous = 1'b0;
      q_txd.delete();
      q_txc.delete();
      q_done.delete();
      tick();
      chk_idle("post");
   endtask

   initial begin
      int n;
      int len;

      tbl.push_back('{16,   8'h00, 64'h07070707070707FD, 8'hFF, 1'b0});
      tbl.push_back('{3,    8'hFE, 64'h07070707FD00FFFE, 8'hF8, 1'b0});
      tbl.push_back('{1,    8'hAA, 64'h070707070707FDAA, 8'hFE, 1'b0});
      tbl.push_back('{7,    8'h10, 64'hFD16151413121110, 8'h80, 1'b0});
      tbl.push_back('{9,    8'h00, 64'h070707070707FD08, 8'hFE, 1'b0});
      tbl.push_back('{12,   8'hF0, 64'h070707FDFBFAF9F8, 8'hF0, 1'b0});
      tbl.push_back('{9600, 8'h33, 64'h07070707070707FD, 8'hFF, 1'b0});
      tbl.push_back('{0,    8'h00, 64'h0, 8'h00, 1'b1});
      tbl.push_back('{9601, 8'h00, 64'h0, 8'h00, 1'b1});
      tbl.push_back('{16383, 8'h00, 64'h0, 8'h00, 1'b1});

      // Reset hold: idle on every cycle.
      tx_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle("rst");
         chk("rst_lerr", 64'(len_err), 64'd0);
      end
      tx_rst = 1'b1;
      tick();
      chk_idle("idle");

      // Reset during DATA aborts immediately, no terminate afterwards.
      issue(32, 8'h40, 3);
      chk("abort_start", xgmii_txd, START_W);
      tick();
      chk("abort_data0", xgmii_txd, 64'h4746454443424140);
      chk("abort_data0_c", 64'(xgmii_txc), 64'h00);
      tx_rst = 1'b0;
      tick();
      chk_idle("abort");
      tx_rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_idle("abort_after");
      end

      // Basic frame: len 16, seed 0, ifg 2.
      model_frame(16, 8'h00, 2);
      issue(16, 8'h00, 2);
      run_stream(1'b0);
      chk("fc_first", 64'(frame_count), 64'd1);

      // Table: terminate word and length-error vectors.
      foreach (tbl[t]) begin
         if (tbl[t].err) begin
            issue(tbl[t].len, tbl[t].seed, 2);
            chk("lerr_pulse", 64'(len_err), 64'd1);
            chk("lerr_busy",  64'(busy), 64'd0);
            chk("lerr_txd",   xgmii_txd, IDLE_W);
            tick();
            chk("lerr_clear", 64'(len_err), 64'd0);
            chk_idle("lerr_after");
         end else begin
            issue(tbl[t].len, tbl[t].seed, 2);
            chk("tbl_start", xgmii_txd, START_W);
            repeat (tbl[t].len / 8 + 1) tick();
            chk("tbl_term_txd", xgmii_txd, tbl[t].term_txd);
            chk("tbl_term_txc", 64'(xgmii_txc), 64'(tbl[t].term_txc));
            n = 0;
            while (busy && n < 2000) begin
               tick();
               n++;
            end
            chk("tbl_busy_drop", 64'(busy), 64'd0);
            fc_exp++;
            chk("tbl_fc", 64'(frame_count), 64'(16'(fc_exp)));
         end
      end

      // Continuous: len 8, ifg 0 (clamped to 2), seeds 00,01,02; start
      // pulses during busy are ignored.
      n = fc_exp;
      cfg_continuous = 1'b1;
      for (int f = 0; f < 3; f++) model_frame(8, 8'(f), 0);
      issue(8, 8'h00, 0);
      run_stream(1'b1);
      chk("cont_fc", 64'(frame_count), 64'(16'(n + 3)));

      // Randomized frames against the reference model.
      for (int r = 0; r < 25; r++) begin
         len = ($urandom_range(0, 4) == 0) ? $urandom_range(41, 300) : $urandom_range(1, 40);
         begin
            logic [7:0] sd;
            int         ig;
            sd = 8'($urandom);
            ig = $urandom_range(0, 6);
            model_frame(len, sd, ig);
            issue(len, sd, ig);
         end
         run_stream(1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) begin
            tick();
            chk_idle("gap");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
